// File: rtl/conv_param_loader.sv
// Loads convolution weights and biases from a byte stream into on-chip memories
// and serves them through synchronous read ports.
module conv_param_loader #(
    parameter int NUM_FILTERS = 4,
    parameter int IN_CHANNELS = 1,
    parameter int KERNEL_SIZE = 3,
    parameter int BIAS_BYTES  = 4,
    localparam int NW = NUM_FILTERS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
    localparam int WA = (NW > 1) ? $clog2(NW) : 1,
    localparam int BA = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
    localparam int BW = BIAS_BYTES * 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          load_done,
    output logic          params_valid,
    input  logic [WA-1:0] w_rd_addr,
    output logic [7:0]    w_rd_data,
    input  logic [BA-1:0] b_rd_addr,
    output logic [BW-1:0] b_rd_data
);

    localparam int KW = (BIAS_BYTES > 1) ? $clog2(BIAS_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, DONE} state_t;

    state_t        state;
    logic [WA-1:0] wcnt;
    logic [BA-1:0] bcnt;
    logic [KW-1:0] kcnt;
    logic [BW-1:0] bias_acc;

    logic          accept;
    logic          last_byte;
    logic          w_we;
    logic          b_we;
    logic [BW-1:0] bias_word;

    logic [7:0]    w_mem [NW];
    logic [BW-1:0] b_mem [NUM_FILTERS];

    // Handshake: a byte moves only when in_valid && in_ready; a byte that
    // coincides with load_start is dropped because the load is restarting.
    assign accept    = in_valid && in_ready && !load_start;
    assign last_byte = (kcnt == KW'(BIAS_BYTES - 1));
    assign w_we      = accept && (state == LOAD_W);
    assign b_we      = accept && (state == LOAD_B) && last_byte;

    always_comb begin
        bias_word = bias_acc;
        bias_word[int'(kcnt) * 8 +: 8] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wcnt         <= '0;
            bcnt         <= '0;
            kcnt         <= '0;
            bias_acc     <= '0;
            in_ready     <= 1'b0;
            load_done    <= 1'b0;
            params_valid <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (load_start) begin
                state        <= LOAD_W;
                wcnt         <= '0;
                bcnt         <= '0;
                kcnt         <= '0;
                bias_acc     <= '0;
                in_ready     <= 1'b1;
                params_valid <= 1'b0;
            end else begin
                case (state)
                    LOAD_W: begin
                        if (accept) begin
                            if (wcnt == WA'(NW - 1)) begin
                                state <= LOAD_B;
                                bcnt  <= '0;
                                kcnt  <= '0;
                            end else begin
                                wcnt <= wcnt + 1'b1;
                            end
                        end
                    end
                    LOAD_B: begin
                        if (accept) begin
                            if (last_byte) begin
                                kcnt     <= '0;
                                bias_acc <= '0;
                                if (bcnt == BA'(NUM_FILTERS - 1)) begin
                                    state        <= DONE;
                                    in_ready     <= 1'b0;
                                    load_done    <= 1'b1;
                                    params_valid <= 1'b1;
                                end else begin
                                    bcnt <= bcnt + 1'b1;
                                end
                            end else begin
                                kcnt     <= kcnt + 1'b1;
                                bias_acc <= bias_word;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory arrays carry no reset so weights can map to LUT RAM and biases
    // to block RAM; contents are only meaningful after a completed load.
    always_ff @(posedge clk) begin
        if (w_we) w_mem[wcnt] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (b_we) b_mem[bcnt] <= bias_word;
    end

    // Registered reads return pre-write contents on a same-cycle collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_rd_data <= '0;
            b_rd_data <= '0;
        end else begin
            w_rd_data <= (int'(w_rd_addr) < NW) ? w_mem[w_rd_addr] : '0;
            b_rd_data <= (int'(b_rd_addr) < NUM_FILTERS) ? b_mem[b_rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_conv_param_loader.sv
// Self-checking bench for conv_param_loader: default-parameter instance plus
// an 8-filter, 2-channel instance for the larger geometry.
module tb_conv_param_loader;

    localparam int NW    = 36;
    localparam int TOT   = 52;
    localparam int G_TOT = 176;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        load_start, in_valid, in_ready, load_done, params_valid;
    logic [7:0]  in_data, w_rd_data;
    logic [5:0]  w_rd_addr;
    logic [1:0]  b_rd_addr;
    logic [31:0] b_rd_data;

    logic        g_load_start, g_in_valid, g_in_ready, g_load_done, g_params_valid;
    logic [7:0]  g_in_data, g_w_rd_data;
    logic [7:0]  g_w_rd_addr;
    logic [2:0]  g_b_rd_addr;
    logic [31:0] g_b_rd_data;

    conv_param_loader u_dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .load_done(load_done),
        .params_valid(params_valid), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data)
    );

    conv_param_loader #(.NUM_FILTERS(8), .IN_CHANNELS(2), .KERNEL_SIZE(3), .BIAS_BYTES(4)) u_big (
        .clk(clk), .rst_n(rst_n), .load_start(g_load_start), .in_valid(g_in_valid),
        .in_data(g_in_data), .in_ready(g_in_ready), .load_done(g_load_done),
        .params_valid(g_params_valid), .w_rd_addr(g_w_rd_addr), .w_rd_data(g_w_rd_data),
        .b_rd_addr(g_b_rd_addr), .b_rd_data(g_b_rd_data)
    );

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0, done_cnt = 0, g_acc_cnt = 0, g_done_cnt = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        bit          is_bias;
        int          addr;
        logic [31:0] exp;
    } vec_t;
    vec_t tab[42];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bv(input int i, input int mode);
        case (mode)
            0:       return 8'(i);
            1:       return 8'hFF;
            default: return 8'(i) ^ 8'hA5;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acceptance / completion monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (load_start) acc_cnt = 0;
            else if (in_valid && in_ready) acc_cnt++;
            if (load_done) begin
                done_cnt++;
                check("done_after_last_byte", 32'(acc_cnt), 32'(TOT));
            end
            if (g_load_start) g_acc_cnt = 0;
            else if (g_in_valid && g_in_ready) g_acc_cnt++;
            if (g_load_done) begin
                g_done_cnt++;
                check("big_done_after_last_byte", 32'(g_acc_cnt), 32'(G_TOT));
            end
        end
    end

    task automatic start_load(input logic v);
        load_start = 1'b1;
        in_valid   = v;
        in_data    = 8'h5A;
        tick();
        load_start = 1'b0;
        in_valid   = 1'b0;
    endtask

    task automatic stream(input int n, input int mode, input bit gaps);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = bv(i, mode);
            tick();
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic read_w(input int addr, input logic [31:0] exp);
        w_rd_addr = 6'(addr);
        exp_q.push_back(exp);
        tick();
        check($sformatf("w_rd[%0d]", addr), {24'b0, w_rd_data}, exp_q.pop_front());
    endtask

    task automatic read_b(input int addr, input logic [31:0] exp);
        b_rd_addr = 2'(addr);
        exp_q.push_back(exp);
        tick();
        check($sformatf("b_rd[%0d]", addr), b_rd_data, exp_q.pop_front());
    endtask

    task automatic build_table(input int mode);
        for (int i = 0; i < NW; i++)
            tab[i] = '{is_bias: 1'b0, addr: i, exp: {24'b0, bv(i, mode)}};
        tab[36] = '{is_bias: 1'b0, addr: 40, exp: 32'h0};
        tab[37] = '{is_bias: 1'b0, addr: 63, exp: 32'h0};
        for (int j = 0; j < 4; j++)
            tab[38 + j] = '{is_bias: 1'b1, addr: j,
                            exp: {bv(NW + 4*j + 3, mode), bv(NW + 4*j + 2, mode),
                                  bv(NW + 4*j + 1, mode), bv(NW + 4*j, mode)}};
    endtask

    task automatic run_table();
        for (int k = 0; k < 42; k++) begin
            if (tab[k].is_bias) read_b(tab[k].addr, tab[k].exp);
            else                read_w(tab[k].addr, tab[k].exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int d0;
        int acc_hold;
        rst_n = 1'b0;
        load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00; w_rd_addr = '0; b_rd_addr = '0;
        g_load_start = 1'b0; g_in_valid = 1'b0; g_in_data = 8'h00; g_w_rd_addr = '0; g_b_rd_addr = '0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_load_done", 32'(load_done), 32'h0);
        check("rst_params_valid", 32'(params_valid), 32'h0);
        check("rst_w_rd_data", 32'(w_rd_data), 32'h0);
        check("rst_b_rd_data", b_rd_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores the stream
        in_valid = 1'b1; in_data = 8'h77;
        repeat (3) tick();
        in_valid = 1'b0;
        check("idle_in_ready", 32'(in_ready), 32'h0);
        check("idle_no_accept", 32'(acc_cnt), 32'h0);

        // Continuous ascending load
        d0 = done_cnt;
        start_load(1'b0);
        check("a_in_ready", 32'(in_ready), 32'h1);
        check("a_pv_low", 32'(params_valid), 32'h0);
        stream(TOT, 0, 1'b0);
        check("a_load_done", 32'(load_done), 32'h1);
        check("a_params_valid", 32'(params_valid), 32'h1);
        check("a_ready_low", 32'(in_ready), 32'h0);
        check("a_accepted", 32'(acc_cnt), 32'(TOT));
        tick();
        check("a_done_single", 32'(load_done), 32'h0);
        in_valid = 1'b1; in_data = 8'h99;
        repeat (2) tick();
        in_valid = 1'b0;
        check("a_done_ignores", 32'(acc_cnt), 32'(TOT));
        check("a_done_count", 32'(done_cnt - d0), 32'h1);
        build_table(0);
        run_table();
        read_b(0, 32'h27262524);
        read_b(3, 32'h33323130);
        check("a_pv_hold", 32'(params_valid), 32'h1);

        // Restart mid-load, then full 0xFF load
        d0 = done_cnt;
        start_load(1'b0);
        stream(20, 0, 1'b0);
        check("c_pv_low", 32'(params_valid), 32'h0);
        start_load(1'b1);
        check("c_restart_count", 32'(acc_cnt), 32'h0);
        stream(TOT, 1, 1'b0);
        tick();
        check("c_done_count", 32'(done_cnt - d0), 32'h1);
        build_table(1);
        run_table();
        w_rd_addr = 6'd7;
        tick();
        check("c_w_signed", 32'($signed(w_rd_data)), 32'hFFFF_FFFF);

        // Gapped ascending load
        d0 = done_cnt;
        start_load(1'b0);
        stream(TOT, 0, 1'b1);
        repeat (2) tick();
        check("b_done_count", 32'(done_cnt - d0), 32'h1);
        check("b_accepted", 32'(acc_cnt), 32'(TOT));
        check("b_params_valid", 32'(params_valid), 32'h1);
        build_table(0);
        run_table();

        // Read-during-write on weight 5
        start_load(1'b0);
        for (int i = 0; i < TOT; i++) begin
            in_valid = 1'b1;
            in_data  = bv(i, 2);
            if (i == 5) begin w_rd_addr = 6'd5;  exp_q.push_back(32'h05); end
            if (i == 6) begin w_rd_addr = 6'd5;  exp_q.push_back(32'hA0); end
            if (i == 7) begin w_rd_addr = 6'd40; exp_q.push_back(32'h00); end
            tick();
            if (i >= 5 && i <= 7)
                check($sformatf("d_rdw_cycle%0d", i), {24'b0, w_rd_data}, exp_q.pop_front());
        end
        in_valid = 1'b0;
        tick();
        build_table(2);
        run_table();

        // Reset in the middle of a load
        start_load(1'b0);
        stream(40, 1, 1'b0);
        acc_hold = acc_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("e_rst_ready", 32'(in_ready), 32'h0);
        check("e_rst_pv", 32'(params_valid), 32'h0);
        check("e_rst_w_rd", 32'(w_rd_data), 32'h0);
        check("e_rst_b_rd", b_rd_data, 32'h0);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h11;
        repeat (4) tick();
        in_valid = 1'b0;
        check("e_no_accept", 32'(acc_cnt), 32'(acc_hold));
        check("e_pv_low", 32'(params_valid), 32'h0);
        check("e_ready_low", 32'(in_ready), 32'h0);

        // Larger geometry: 144 weights + 8 biases
        d0 = g_done_cnt;
        g_load_start = 1'b1;
        tick();
        g_load_start = 1'b0;
        for (int i = 0; i < G_TOT + 3; i++) begin
            g_in_valid = 1'b1;
            g_in_data  = 8'(i);
            tick();
        end
        g_in_valid = 1'b0;
        check("g_accepted", 32'(g_acc_cnt), 32'(G_TOT));
        check("g_done_count", 32'(g_done_cnt - d0), 32'h1);
        check("g_params_valid", 32'(g_params_valid), 32'h1);
        g_w_rd_addr = 8'd143; exp_q.push_back(32'h8F); tick();
        check("g_w_rd[143]", {24'b0, g_w_rd_data}, exp_q.pop_front());
        g_w_rd_addr = 8'd144; exp_q.push_back(32'h00); tick();
        check("g_w_rd[144]", {24'b0, g_w_rd_data}, exp_q.pop_front());
        g_b_rd_addr = 3'd7; exp_q.push_back(32'hAFAEADAC); tick();
        check("g_b_rd[7]", g_b_rd_data, exp_q.pop_front());
        g_b_rd_addr = 3'd0; exp_q.push_back(32'h93929190); tick();
        check("g_b_rd[0]", g_b_rd_data, exp_q.pop_front());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_param_loader.md
CONV_PARAM_LOADER -- requirements
Module: conv_param_loader

Interface
REQ-001 The block SHALL have parameter NUM_FILTERS, default 4: number of conv filters.
REQ-002 The block SHALL have parameter IN_CHANNELS, default 1: input channels per filter.
REQ-003 The block SHALL have parameter KERNEL_SIZE, default 3: kernel height and width.
REQ-004 The block SHALL have parameter BIAS_BYTES, default 4: bytes per bias word, little-endian; bias width is BIAS_BYTES*8.
REQ-005 The block SHALL derive NW = NUM_FILTERS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE; WA = clog2(NW); BA = clog2(NUM_FILTERS), minimum 1 each.
REQ-006 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load_start  in  1  single-cycle request to begin a new parameter load
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  block accepts a byte this cycle
- load_done  out  1  single-cycle pulse when the last byte is stored
- params_valid  out  1  complete parameter set held
- w_rd_addr  in  WA  weight read address (filter-major, then channel, row, column)
- w_rd_data  out  8  weight read data, signed
- b_rd_addr  in  BA  bias read address
- b_rd_data  out  BIAS_BYTES*8  bias read data, signed

Function
REQ-007 The FSM SHALL have states IDLE, LOAD_W, LOAD_B, DONE.
REQ-008 A byte SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-009 in_ready SHALL be 1 in LOAD_W and LOAD_B and 0 in IDLE and DONE.
REQ-010 load_start in any state SHALL go to LOAD_W, clear the weight and byte counters, and clear params_valid on the next edge.
- load_start during LOAD_W or LOAD_B restarts the load.
- A byte presented with load_start is discarded.
REQ-011 In LOAD_W, each accepted byte SHALL be written to weight address wcnt, and wcnt SHALL increment by 1.
REQ-012 On acceptance of weight byte NW-1, the FSM SHALL go to LOAD_B with the bias counter and byte counter at 0.
REQ-013 In LOAD_B, accepted bytes SHALL be assembled little-endian: byte k of a word fills bits [8k+7:8k].
REQ-014 On acceptance of byte BIAS_BYTES-1, the assembled word SHALL be written to bias address bcnt, and bcnt SHALL increment.
REQ-015 On acceptance of the last byte of bias NUM_FILTERS-1, the FSM SHALL go to DONE.
- On the following cycle, load_done = 1 for exactly 1 cycle and params_valid = 1.
REQ-016 params_valid SHALL stay 1 in DONE until load_start or reset.
REQ-017 Total accepted bytes per load SHALL be exactly NW + NUM_FILTERS*BIAS_BYTES; in_valid outside LOAD_W/LOAD_B SHALL be ignored.
REQ-018 Reads SHALL be synchronous with 1-cycle latency (data appears after the edge following address presentation) and SHALL be available in every state.
REQ-019 A read of an address that is being written in the same cycle SHALL return the old contents.
REQ-020 A read address >= NW (weights) or >= NUM_FILTERS (biases) SHALL return 0.
REQ-021 Weight storage SHALL be distributed RAM; bias storage SHALL be block RAM where the tool permits.

Reset
REQ-022 While rst_n = 0, the block SHALL immediately force:
- state = IDLE, all counters = 0, assembly register = 0
- in_ready = 0, load_done = 0, params_valid = 0
- w_rd_data = 0, b_rd_data = 0
REQ-023 Parameter memory contents SHALL NOT be reset; they are undefined until the first completed load.
REQ-024 Reset during LOAD_W or LOAD_B SHALL abandon the load; params_valid SHALL remain 0 until a full new load completes.

Verification
REQ-025 Default parameters, load_start, then 52 bytes 0x00..0x33 with continuous in_valid -> weight reads at addresses 0..35 return 0x00..0x23; bias reads 0..3 return 0x27262524, 0x2B2A2928, 0x2F2E2D2C, 0x33323130; load_done pulses once; params_valid = 1.
REQ-026 The same load with in_valid toggled 1,0,1,0 -> identical memory contents; load_done asserts only after the 52nd accepted byte.
REQ-027 A second load_start after 20 bytes, then a full 52-byte load of 0xFF -> all weights read 0xFF (signed -1), all biases read 0xFFFFFFFF; exactly one load_done pulse.
REQ-028 rst_n asserted after byte 40 -> in_ready = 0 and params_valid = 0 immediately; bytes presented with in_valid = 1 before the next load_start are not accepted.
REQ-029 Read w_rd_addr = 5 in the cycle byte 5 is written -> old value returned that cycle, new value on the next read; w_rd_addr = 40 returns 0.
REQ-030 NUM_FILTERS = 8, IN_CHANNELS = 2, KERNEL_SIZE = 3 -> exactly 144 + 32 bytes accepted; bias 7 assembled from bytes 172..175.
